// File: rtl/hp_axi_mem_responder.sv
// AXI slave backed by a beat-wide memory: independent INCR write and read FSMs,
// byte-strobed writes, registered read data, SLVERR on wlast misplacement.
module hp_axi_mem_responder #(
    parameter int data_width_p = 64,
    parameter int addr_width_p = 32,
    parameter int id_width_p   = 6,
    parameter int els_p        = 1024
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [addr_width_p-1:0]   s_axi_awaddr,
    input  logic [id_width_p-1:0]     s_axi_awid,
    input  logic [7:0]                s_axi_awlen,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [data_width_p-1:0]   s_axi_wdata,
    input  logic [data_width_p/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [id_width_p-1:0]     s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [addr_width_p-1:0]   s_axi_araddr,
    input  logic [id_width_p-1:0]     s_axi_arid,
    input  logic [7:0]                s_axi_arlen,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [data_width_p-1:0]   s_axi_rdata,
    output logic [id_width_p-1:0]     s_axi_rid,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    localparam int strb_w = data_width_p / 8;
    localparam int byte_w = $clog2(strb_w);
    localparam int idx_w  = $clog2(els_p);
    localparam logic [idx_w-1:0] idx_one = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [data_width_p-1:0] mem [els_p];

    wstate_t          w_state;
    logic [7:0]       w_len;
    logic [7:0]       w_beat;
    logic [idx_w-1:0] w_idx;
    logic             w_err;

    rstate_t          r_state;
    logic [7:0]       r_len;
    logic [7:0]       r_beat;
    logic [idx_w-1:0] r_idx;

    logic [idx_w-1:0] aw_idx;
    logic [idx_w-1:0] ar_idx;
    logic [idx_w-1:0] r_idx_nxt;
    logic [7:0]       r_beat_nxt;
    logic             w_fire;
    logic             w_last_beat;
    logic             w_bad;
    logic             unused_addr;

    // Only the beat-index field of each address matters; the rest is ignored.
    assign aw_idx      = s_axi_awaddr[idx_w+byte_w-1:byte_w];
    assign ar_idx      = s_axi_araddr[idx_w+byte_w-1:byte_w];
    assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

    assign w_fire      = s_axi_wvalid & s_axi_wready;
    assign w_last_beat = (w_beat == w_len);
    assign w_bad       = (s_axi_wlast != w_last_beat);
    assign r_idx_nxt   = r_idx + idx_one;
    assign r_beat_nxt  = r_beat + 8'd1;
    assign s_axi_rresp = 2'b00;

    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int b = 0; b < strb_w; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            s_axi_bresp   <= 2'b00;
            w_len         <= '0;
            w_beat        <= '0;
            w_idx         <= '0;
            w_err         <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        s_axi_bid     <= s_axi_awid;
                        w_len         <= s_axi_awlen;
                        w_beat        <= '0;
                        w_idx         <= aw_idx;
                        w_err         <= 1'b0;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    // Burst length comes from awlen; wlast only grades the initiator.
                    if (w_fire) begin
                        w_idx  <= w_idx + idx_one;
                        w_beat <= w_beat + 8'd1;
                        w_err  <= w_err | w_bad;
                        if (w_last_beat) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (w_err | w_bad) ? 2'b10 : 2'b00;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // rdata is fetched one beat ahead so it is ready the cycle rvalid rises.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            r_len         <= '0;
            r_beat        <= '0;
            r_idx         <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rdata   <= mem[ar_idx];
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_len         <= s_axi_arlen;
                        r_beat        <= '0;
                        r_idx         <= ar_idx;
                        r_state       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            s_axi_rdata <= mem[r_idx_nxt];
                            s_axi_rlast <= (r_beat_nxt == r_len);
                            r_idx       <= r_idx_nxt;
                            r_beat      <= r_beat_nxt;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_axi_mem_responder.sv
// Directed bench for hp_axi_mem_responder: a table of write/read bursts with
// hand-computed results plus sequences for reset-abort and same-edge read/write.
module tb_hp_axi_mem_responder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] awaddr = '0;
    logic [5:0]  awid = '0;
    logic [7:0]  awlen = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [5:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [5:0]  arid = '0;
    logic [7:0]  arlen = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [5:0]  rid;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    hp_axi_mem_responder #(
        .data_width_p(64),
        .addr_width_p(32),
        .id_width_p(6),
        .els_p(1024)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axi_awaddr(awaddr),
        .s_axi_awid(awid),
        .s_axi_awlen(awlen),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid),
        .s_axi_wready(wready),
        .s_axi_bid(bid),
        .s_axi_bresp(bresp),
        .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_araddr(araddr),
        .s_axi_arid(arid),
        .s_axi_arlen(arlen),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata(rdata),
        .s_axi_rid(rid),
        .s_axi_rresp(rresp),
        .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid),
        .s_axi_rready(rready)
    );

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [5:0]  id;
        logic [7:0]  len;
        logic [63:0] data;
        logic [7:0]  strb;
        int          bad_last;
        bit          gap;
        bit          stall;
        logic [1:0]  exp_resp;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Write beats carry data+beat; reads expect exp_data+beat.
    task automatic applyStimulus(input vec_t v);
        logic [63:0] held;
        if (v.is_write) begin
            awaddr = v.addr; awid = v.id; awlen = v.len; awvalid = 1'b1;
            checkOutput("awready_idle", 64'(awready), 64'd1);
            tick();
            awvalid = 1'b0;
            checkOutput("wready_after_aw", 64'(wready), 64'd1);
            for (int beat = 0; beat <= int'(v.len); beat++) begin
                if (v.gap && (beat % 2 == 1)) begin
                    wvalid = 1'b0;
                    tick();
                end
                wvalid = 1'b1;
                wdata  = v.data + 64'(beat);
                wstrb  = v.strb;
                wlast  = (v.bad_last >= 0) ? (beat == v.bad_last) : (beat == int'(v.len));
                tick();
            end
            wvalid = 1'b0; wlast = 1'b0;
            checkOutput("bvalid_after_last_w", 64'(bvalid), 64'd1);
            checkOutput("wready_in_resp", 64'(wready), 64'd0);
            checkOutput("bid", 64'(bid), 64'(v.id));
            checkOutput("bresp", 64'(bresp), 64'(v.exp_resp));
            bready = 1'b1;
            tick();
            bready = 1'b0;
            checkOutput("awready_after_b", 64'(awready), 64'd1);
            checkOutput("bvalid_after_b", 64'(bvalid), 64'd0);
        end else begin
            araddr = v.addr; arid = v.id; arlen = v.len; arvalid = 1'b1;
            checkOutput("arready_idle", 64'(arready), 64'd1);
            tick();
            arvalid = 1'b0;
            checkOutput("rvalid_after_ar", 64'(rvalid), 64'd1);
            for (int beat = 0; beat <= int'(v.len); beat++) begin
                if (v.stall && (beat % 2 == 0)) begin
                    rready = 1'b0;
                    held = rdata;
                    tick();
                    checkOutput("rdata_stable_stall", rdata, held);
                    checkOutput("rvalid_stable_stall", 64'(rvalid), 64'd1);
                end
                rready = 1'b1;
                checkOutput("rdata", rdata, v.exp_data + 64'(beat));
                checkOutput("rlast", 64'(rlast), 64'(beat == int'(v.len)));
                checkOutput("rid", 64'(rid), 64'(v.id));
                checkOutput("rresp", 64'(rresp), 64'd0);
                tick();
            end
            rready = 1'b0;
            checkOutput("arready_after_rlast", 64'(arready), 64'd1);
            checkOutput("rvalid_after_rlast", 64'(rvalid), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //          wr  addr          id     len     data                    strb   bad gap stl resp   exp_data
        vecs[0]  = '{1, 32'h40,   6'd5,  8'd0,   64'h1122334455667788, 8'hFF, -1, 0, 0, 2'b00, 64'h0};
        vecs[1]  = '{0, 32'h40,   6'd3,  8'd0,   64'h0,                8'h00, -1, 0, 0, 2'b00, 64'h1122334455667788};
        vecs[2]  = '{1, 32'h100,  6'd1,  8'd3,   64'h0,                8'hFF, -1, 1, 0, 2'b00, 64'h0};
        vecs[3]  = '{0, 32'h100,  6'd2,  8'd3,   64'h0,                8'h00, -1, 0, 1, 2'b00, 64'h0};
        vecs[4]  = '{1, 32'h200,  6'd0,  8'd0,   64'hFFFFFFFFFFFFFFFF, 8'hFF, -1, 0, 0, 2'b00, 64'h0};
        vecs[5]  = '{1, 32'h200,  6'd7,  8'd0,   64'h0,                8'h0F, -1, 0, 0, 2'b00, 64'h0};
        vecs[6]  = '{0, 32'h200,  6'd4,  8'd0,   64'h0,                8'h00, -1, 0, 0, 2'b00, 64'hFFFFFFFF00000000};
        vecs[7]  = '{1, 32'h1FF8, 6'd9,  8'd1,   64'hA00000000000000A, 8'hFF, -1, 0, 0, 2'b00, 64'h0};
        vecs[8]  = '{0, 32'h1FF8, 6'd10, 8'd0,   64'h0,                8'h00, -1, 0, 0, 2'b00, 64'hA00000000000000A};
        vecs[9]  = '{0, 32'h0,    6'd11, 8'd0,   64'h0,                8'h00, -1, 0, 0, 2'b00, 64'hA00000000000000B};
        vecs[10] = '{1, 32'h300,  6'd12, 8'd2,   64'h77,               8'hFF,  1, 0, 0, 2'b10, 64'h0};
        vecs[11] = '{0, 32'h300,  6'd13, 8'd2,   64'h0,                8'h00, -1, 0, 0, 2'b00, 64'h77};
        vecs[12] = '{1, 32'h800,  6'd63, 8'd255, 64'h1000,             8'hFF, -1, 0, 0, 2'b00, 64'h0};
        vecs[13] = '{0, 32'h800,  6'd62, 8'd255, 64'h0,                8'h00, -1, 0, 1, 2'b00, 64'h1000};

        #12;
        checkOutput("reset_awready", 64'(awready), 64'd1);
        checkOutput("reset_arready", 64'(arready), 64'd1);
        checkOutput("reset_wready", 64'(wready), 64'd0);
        checkOutput("reset_bvalid", 64'(bvalid), 64'd0);
        checkOutput("reset_rvalid", 64'(rvalid), 64'd0);
        checkOutput("reset_rdata", rdata, 64'd0);
        checkOutput("reset_bid_bresp", 64'({bid, bresp}), 64'd0);
        tick();
        aresetn = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            tick();
        end

        // Reset in the middle of an 8-beat read, after two beats are taken.
        araddr = 32'h800; arid = 6'd21; arlen = 8'd7; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        tick();
        tick();
        aresetn = 1'b0;
        #1;
        checkOutput("abort_rvalid", 64'(rvalid), 64'd0);
        checkOutput("abort_arready", 64'(arready), 64'd1);
        checkOutput("abort_rlast", 64'(rlast), 64'd0);
        checkOutput("abort_rdata_rid", rdata ^ 64'(rid), 64'd0);
        rready = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        checkOutput("post_reset_arready", 64'(arready), 64'd1);
        applyStimulus('{0, 32'h800, 6'd22, 8'd7, 64'h0, 8'h00, -1, 0, 0, 2'b00, 64'h1000});
        tick();

        // Read loading an index on the same edge it is being written sees old data.
        awaddr = 32'h40; awid = 6'd1; awlen = 8'd0; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 64'hDEADBEEFCAFEF00D; wstrb = 8'hFF; wlast = 1'b1;
        araddr = 32'h40; arid = 6'd2; arlen = 8'd0; arvalid = 1'b1;
        tick();
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
        checkOutput("same_edge_rdata", rdata, 64'h1122334455667788);
        checkOutput("same_edge_bvalid", 64'(bvalid), 64'd1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        tick();
        applyStimulus('{0, 32'h40, 6'd3, 8'd0, 64'h0, 8'h00, -1, 0, 0, 2'b00, 64'hDEADBEEFCAFEF00D});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
